// File: rtl/greenhouse_pkg.sv
// -----------------------------------------------------------------------------
// greenhouse_pkg
// Shared types and constants for the greenhouse actuation blocks.
//   planner_state_t : irrigation_planner FSM states (IDLE, CALC, RUN, GAP)
//   sat8            : clamps a 16-bit unsigned value to 8 bits (255 ceiling)
//   DEF_*           : default thresholds and timings used as parameter defaults
// DEF_TIMEOUT_CYCLES is only consumed when IRRIGATION_PLANNER_TIMEOUT_EN is
// defined (RUN watchdog in the planner).
// -----------------------------------------------------------------------------
package greenhouse_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RUN  = 2'd2,
      GAP  = 2'd3
   } planner_state_t;

   localparam logic [7:0]  DEF_MOIST_TARGET   = 8'd128;
   localparam logic [7:0]  DEF_TEMP_LIMIT     = 8'd30;
   localparam int          DEF_IRR_SHIFT      = 1;
   localparam int          DEF_VENT_SHIFT     = 2;
   localparam logic [7:0]  DEF_SETTLE_CYCLES  = 8'd4;
   localparam int          DEF_MIN_GAP        = 8;
   localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd1000;

   // Anything that does not fit in 8 bits becomes 255.
   function automatic logic [7:0] sat8(input logic [15:0] value);
      return (value > 16'd255) ? 8'hFF : value[7:0];
   endfunction

endpackage

// File: rtl/duration_calc.sv
// -----------------------------------------------------------------------------
// duration_calc
// Purely combinational conversion of one sensor sample into phase lengths.
// Ports:
//   soil_moisture (in, 8)  : latched moisture reading
//   temperature   (in, 8)  : latched temperature reading
//   irr           (out, 8) : irrigation phase length, never 0
//   vent          (out, 8) : ventilation phase length, saturated, never 0
//   skip          (out, 1) : neither a moisture deficit nor a heat excess
// -----------------------------------------------------------------------------
module duration_calc
   import greenhouse_pkg::*;
#(
   parameter logic [7:0] MOIST_TARGET = DEF_MOIST_TARGET,
   parameter logic [7:0] TEMP_LIMIT   = DEF_TEMP_LIMIT,
   parameter int         IRR_SHIFT    = DEF_IRR_SHIFT,
   parameter int         VENT_SHIFT   = DEF_VENT_SHIFT
) (
   input  logic [7:0] soil_moisture,
   input  logic [7:0] temperature,
   output logic [7:0] irr,
   output logic [7:0] vent,
   output logic       skip
);

   logic        need_irr;
   logic        need_vent;
   logic [7:0]  deficit;
   logic [7:0]  excess;
   logic [7:0]  irr_raw;
   logic [15:0] vent_wide;

   // Skip is decided on whether a deficit/excess exists at all, not on the
   // shifted value: a 1-count deficit shifts to 0 yet still runs a minimal
   // cycle. The downstream state machine cannot take zero-length phases, so
   // both lengths are clamped to at least 1.
   always_comb begin
      need_irr  = (soil_moisture < MOIST_TARGET);
      need_vent = (temperature > TEMP_LIMIT);
      deficit   = need_irr  ? (MOIST_TARGET - soil_moisture) : 8'd0;
      excess    = need_vent ? (temperature - TEMP_LIMIT)     : 8'd0;
      irr_raw   = deficit >> IRR_SHIFT;
      vent_wide = {8'd0, excess} << VENT_SHIFT;
      irr       = (irr_raw == 8'd0)    ? 8'd1 : irr_raw;
      vent      = (vent_wide == 16'd0) ? 8'd1 : sat8(vent_wide);
      skip      = !need_irr && !need_vent;
   end

endmodule

// File: rtl/irrigation_planner.sv
// -----------------------------------------------------------------------------
// irrigation_planner
// Turns periodic soil-moisture/temperature samples into the three phase
// durations of one greenhouse actuation cycle and runs the enable/done
// handshake with the downstream state_machine, with an enforced idle gap
// between cycles and a one-deep buffer for samples arriving while busy.
// Optional feature macro: IRRIGATION_PLANNER_TIMEOUT_EN
//   defined   : RUN is abandoned after TIMEOUT_CYCLES without done; fault sets
//   undefined : RUN waits for done indefinitely; fault is tied low
// Ports:
//   clk             (in)      : system clock, rising edge
//   reset           (in)      : asynchronous reset, active low
//   sample_valid    (in)      : single-cycle strobe for the sensor inputs
//   soil_moisture   (in, 8)   : unsigned moisture reading
//   temperature     (in, 8)   : unsigned temperature reading
//   done            (in)      : cycle-complete level from state_machine
//   enable          (out)     : start/hold request to state_machine
//   state1_duration (out, 8)  : irrigation phase length
//   state2_duration (out, 8)  : settle phase length
//   state3_duration (out, 8)  : ventilation phase length
//   busy            (out)     : high in every state except IDLE
//   cycle_count     (out, 16) : completed cycles, wrapping
//   fault           (out)     : sticky timeout flag
// -----------------------------------------------------------------------------
module irrigation_planner
   import greenhouse_pkg::*;
#(
   parameter logic [7:0]  MOIST_TARGET   = DEF_MOIST_TARGET,
   parameter logic [7:0]  TEMP_LIMIT     = DEF_TEMP_LIMIT,
   parameter int          IRR_SHIFT      = DEF_IRR_SHIFT,
   parameter int          VENT_SHIFT     = DEF_VENT_SHIFT,
   parameter logic [7:0]  SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int          MIN_GAP        = DEF_MIN_GAP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_valid,
   input  logic [7:0]  soil_moisture,
   input  logic [7:0]  temperature,
   input  logic        done,
   output logic        enable,
   output logic [7:0]  state1_duration,
   output logic [7:0]  state2_duration,
   output logic [7:0]  state3_duration,
   output logic        busy,
   output logic [15:0] cycle_count,
   output logic        fault
);

   // GAP occupies exactly MIN_GAP cycles: the counter starts at 0 on entry
   // and the exit happens on the edge where it reads MIN_GAP-1.
   localparam logic [15:0] GAP_LAST = 16'(MIN_GAP - 1);

   planner_state_t state;
   planner_state_t state_next;

   logic [7:0]  cur_moisture;
   logic [7:0]  cur_temperature;
   logic [7:0]  pend_moisture;
   logic [7:0]  pend_temperature;
   logic        pend_valid;
   logic [15:0] gap_cnt;
   logic        gap_done;
   logic        cycle_done;
   logic [7:0]  irr;
   logic [7:0]  vent;
   logic        skip;

`ifdef IRRIGATION_PLANNER_TIMEOUT_EN
   localparam logic [15:0] RUN_LAST = TIMEOUT_CYCLES - 16'd1;
   logic [15:0] run_cnt;
   logic        timeout_hit;
`endif

   duration_calc #(
      .MOIST_TARGET (MOIST_TARGET),
      .TEMP_LIMIT   (TEMP_LIMIT),
      .IRR_SHIFT    (IRR_SHIFT),
      .VENT_SHIFT   (VENT_SHIFT)
   ) u_duration_calc (
      .soil_moisture (cur_moisture),
      .temperature   (cur_temperature),
      .irr           (irr),
      .vent          (vent),
      .skip          (skip)
   );

   assign gap_done = (state == GAP) && (gap_cnt == GAP_LAST);

   // Decoding straight from the state register means an asynchronous reset
   // drops enable and busy immediately, without waiting for a clock edge.
   assign enable = (state == RUN);
   assign busy   = (state != IDLE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. In RUN a returned done takes priority over an
   // expiring watchdog on the same edge, so such a cycle still counts.
   always_comb begin
      state_next = state;
      cycle_done = 1'b0;
`ifdef IRRIGATION_PLANNER_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (sample_valid) begin
               state_next = CALC;
            end
         end
         CALC: begin
            state_next = skip ? IDLE : RUN;
         end
         RUN: begin
            if (done) begin
               state_next = GAP;
               cycle_done = 1'b1;
            end
`ifdef IRRIGATION_PLANNER_TIMEOUT_EN
            else if (run_cnt == RUN_LAST) begin
               state_next  = GAP;
               timeout_hit = 1'b1;
            end
`endif
         end
         GAP: begin
            if (gap_done) begin
               state_next = (pend_valid || sample_valid) ? CALC : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Working sample fed to duration_calc. Leaving GAP, a sample strobed on
   // that very edge is newer than the buffered one and is used directly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_moisture    <= 8'd0;
         cur_temperature <= 8'd0;
      end else if ((state == IDLE) && sample_valid) begin
         cur_moisture    <= soil_moisture;
         cur_temperature <= temperature;
      end else if (gap_done) begin
         if (sample_valid) begin
            cur_moisture    <= soil_moisture;
            cur_temperature <= temperature;
         end else if (pend_valid) begin
            cur_moisture    <= pend_moisture;
            cur_temperature <= pend_temperature;
         end
      end
   end

   // One-deep pending buffer: newest sample wins, consumed on GAP exit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_valid       <= 1'b0;
         pend_moisture    <= 8'd0;
         pend_temperature <= 8'd0;
      end else if (gap_done) begin
         pend_valid <= 1'b0;
      end else if (sample_valid && (state != IDLE)) begin
         pend_valid       <= 1'b1;
         pend_moisture    <= soil_moisture;
         pend_temperature <= temperature;
      end
   end

   // Durations load only on CALC->RUN, so they are frozen whenever enable
   // is high and keep their last value afterwards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state1_duration <= 8'd0;
         state2_duration <= 8'd0;
         state3_duration <= 8'd0;
      end else if ((state == CALC) && !skip) begin
         state1_duration <= irr;
         state2_duration <= SETTLE_CYCLES;
         state3_duration <= vent;
      end
   end

   // Gap timer, held at zero outside GAP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gap_cnt <= 16'd0;
      end else if (state == GAP) begin
         gap_cnt <= gap_cnt + 16'd1;
      end else begin
         gap_cnt <= 16'd0;
      end
   end

   // Completed-cycle counter; wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_count <= 16'd0;
      end else if (cycle_done) begin
         cycle_count <= cycle_count + 16'd1;
      end
   end

`ifdef IRRIGATION_PLANNER_TIMEOUT_EN
   // RUN watchdog, held at zero outside RUN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_cnt <= 16'd0;
      end else if (state == RUN) begin
         run_cnt <= run_cnt + 16'd1;
      end else begin
         run_cnt <= 16'd0;
      end
   end

   // Fault stays set until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault <= 1'b0;
      end else if (timeout_hit) begin
         fault <= 1'b1;
      end
   end
`else
   assign fault = 1'b0;
`endif

endmodule
